signed_product_sequencer: RTL and testbench

//  Signed front/back end for the unsigned approximate multiplier core.
//  - Accepts two's-complement operand pairs on a valid/ready handshake.
//  - Converts them to sign-magnitude and drives the core magnitudes.
//  - Waits the core's fixed latency, captures the unsigned product and re-applies the sign.
//  - Returns a two's-complement product on a valid/ready handshake.
//  - One transaction in flight at a time.

---
 rtl/signed_product_sequencer.sv | 139 +++++++++++++
 tb/tb_signed_product_sequencer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/signed_product_sequencer.sv
// signed_product_sequencer
//   Signed wrapper around an unsigned multiplier core. Takes two's-complement
//   operand pairs, hands their magnitudes to the core, waits the core latency,
//   then returns the product with the sign re-applied. Only one transaction is
//   in flight at a time.
//
// Ports
//   Clk         rising-edge clock
//   Rst         asynchronous active-low reset
//   in_valid    operand pair valid           in_ready   pair accepted when high
//   x, y        signed operands (WIDTH)
//   core_x/y    operand magnitudes to core   core_start one-cycle core launch
//   core_p      unsigned core product (2*WIDTH)
//   out_valid   product valid                out_ready  downstream accepts p
//   p           signed product (2*WIDTH)
//
// Optional feature macro: ZERO_BYPASS_EN
//   When defined, a pair with a zero operand skips the core entirely and
//   reports p=0 one edge after accept; core_x/core_y keep their old values.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for an operand pair
// WAIT  | core running; cnt counts down to the capture edge
// DONE  | product presented, held until out_ready
module signed_product_sequencer #(
  parameter int WIDTH    = 128,
  parameter int CORE_LAT = 2
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic [WIDTH-1:0]     core_x,
  output logic [WIDTH-1:0]     core_y,
  output logic                 core_start,
  input  logic [2*WIDTH-1:0]   core_p,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);

  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]         CNT_LD  = 4'(CORE_LAT);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic                neg;
  logic [WIDTH-1:0]    mag_x, mag_y;
  logic [2*WIDTH-1:0]  p_signed, p_res;
  logic                accept, capture;

  // -2^(W-1) wraps to 2^(W-1), which is exactly the right unsigned magnitude.
  assign mag_x = x[WIDTH-1] ? (~x + ONE_W) : x;
  assign mag_y = y[WIDTH-1] ? (~y + ONE_W) : y;
  // A zero product negates back to zero, so neg=1 cannot produce all-ones.
  assign p_signed = neg ? (~core_p + ONE_2W) : core_p;

  assign accept   = (state == IDLE) && in_valid;
  // The first WAIT cycle (core_start high) is not counted, which lines the
  // capture edge up with the core's output after its full latency.
  assign capture  = (state == WAIT) && !core_start && (cnt == 4'd1);
  assign in_ready = Rst && (state == IDLE);

`ifdef ZERO_BYPASS_EN
  logic skip;
  logic zero_in;
  assign zero_in = (x == '0) || (y == '0);
  assign p_res   = skip ? '0 : p_signed;
`else
  assign p_res   = p_signed;
`endif

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = WAIT;
      WAIT:    if (capture)   state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      cnt        <= '0;
      neg        <= 1'b0;
      core_x     <= '0;
      core_y     <= '0;
      core_start <= 1'b0;
      out_valid  <= 1'b0;
      p          <= '0;
`ifdef ZERO_BYPASS_EN
      skip       <= 1'b0;
`endif
    end else begin
      core_start <= 1'b0;
      if (accept) begin
        neg <= x[WIDTH-1] ^ y[WIDTH-1];
        cnt <= CNT_LD;
`ifdef ZERO_BYPASS_EN
        skip <= zero_in;
        if (zero_in) begin
          // Reuse WAIT with a count of one so the result lands one edge later.
          cnt <= 4'd1;
        end else begin
          core_x     <= mag_x;
          core_y     <= mag_y;
          core_start <= 1'b1;
        end
`else
        core_x     <= mag_x;
        core_y     <= mag_y;
        core_start <= 1'b1;
`endif
      end else if ((state == WAIT) && !core_start) begin
        cnt <= cnt - 4'd1;
      end

      if (capture) begin
        out_valid <= 1'b1;
        p         <= p_res;
      end else if ((state == DONE) && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_signed_product_sequencer.sv
module tb_signed_product_sequencer;

  localparam int W   = 8;
  localparam int LAT = 2;
`ifdef ZERO_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic           Clk = 1'b0;
  logic           Rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           out_ready = 1'b0;
  logic [W-1:0]   x = '0;
  logic [W-1:0]   y = '0;
  logic           in_ready;
  logic [W-1:0]   core_x, core_y;
  logic           core_start;
  logic [2*W-1:0] core_p;
  logic           out_valid;
  logic [2*W-1:0] p;

  signed_product_sequencer #(.WIDTH(W), .CORE_LAT(LAT)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .core_x(core_x), .core_y(core_y), .core_start(core_start),
    .core_p(core_p), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  always #5 Clk = ~Clk;

  // Ideal core: product of the presented magnitudes, two register stages late.
  logic [2*W-1:0] core_d1, core_d2;
  always @(posedge Clk) begin
    core_d1 <= 16'(core_x) * 16'(core_y);
    core_d2 <= core_d1;
  end
  assign core_p = core_d2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] sprod(input logic [7:0] a, input logic [7:0] b);
    int ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    return 16'(ia * ib);
  endfunction

  function automatic logic [7:0] mag(input logic [7:0] a);
    int ia;
    ia = $signed(a);
    if (ia < 0) ia = -ia;
    return 8'(ia);
  endfunction

  // Transaction-level reference: a busy flag, a due edge for the result and
  // the arithmetic product; no knowledge of the DUT's internal states.
  int          cyc = 0;
  bit          m_busy, m_pend, m_valid, m_start;
  int          m_due;
  logic [15:0] m_prod, m_p;
  logic [7:0]  m_cx, m_cy;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_busy  <= 1'b0;
      m_pend  <= 1'b0;
      m_valid <= 1'b0;
      m_start <= 1'b0;
      m_p     <= '0;
      m_cx    <= '0;
      m_cy    <= '0;
    end else begin
      cyc     <= cyc + 1;
      m_start <= 1'b0;
      if (m_valid && out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end else if (m_pend && (cyc + 1 == m_due)) begin
        m_pend  <= 1'b0;
        m_valid <= 1'b1;
        m_p     <= m_prod;
      end else if (!m_busy && in_valid) begin
        m_busy <= 1'b1;
        m_pend <= 1'b1;
        m_prod <= sprod(x, y);
        if (BYP && (x == 0 || y == 0)) begin
          m_due <= cyc + 2;
        end else begin
          m_due   <= cyc + 1 + LAT + 1;
          m_cx    <= mag(x);
          m_cy    <= mag(y);
          m_start <= 1'b1;
        end
      end
    end
  end

  bit run_cmp = 1'b0;
  always @(negedge Clk) begin
    if (run_cmp && Rst) begin
      chk("in_ready", in_ready, !m_busy);
      chk("out_valid", out_valid, m_valid);
      chk("core_start", core_start, m_start);
      chk("core_x", core_x, m_cx);
      chk("core_y", core_y, m_cy);
      if (m_valid) chk("p", p, m_p);
    end
  end

  bit          collect = 1'b0;
  logic [15:0] got_q[$];
  always @(negedge Clk) begin
    if (collect && Rst && out_valid && out_ready) got_q.push_back(p);
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] cx, input logic [7:0] cy,
                      input logic [15:0] lit, input int lat_lit, input int hold);
    int n;
    @(negedge Clk);
    chk("in_ready_pre", in_ready, 1);
    x = a; y = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge Clk); #1;
    chk("lit_core_x", core_x, cx);
    chk("lit_core_y", core_y, cy);
    chk("lit_core_start", core_start, !(BYP && (a == 0 || b == 0)));
    chk("in_ready_busy", in_ready, 0);
    @(negedge Clk);
    in_valid = 1'b0;
    n = (out_valid) ? 0 : 1;
    while (!out_valid && n < 20) begin
      @(posedge Clk); #1;
      if (!out_valid) n++;
    end
    chk("lit_latency", n, lat_lit);
    chk("lit_p", p, lit);
    for (int i = 0; i < hold; i++) begin
      @(negedge Clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_p", p, lit);
    end
    @(negedge Clk);
    out_ready = 1'b1;
    @(posedge Clk); #1;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    @(negedge Clk);
    out_ready = 1'b0;
  endtask

  logic [7:0]  bx [4] = '{8'd3, 8'hFE, 8'd127, 8'hFF};
  logic [7:0]  by [4] = '{8'd4, 8'd5, 8'd127, 8'hFF};
  logic [15:0] bp [4] = '{16'h000C, 16'hFFF6, 16'h3F01, 16'h0001};
  int          acc_t [4];

  initial begin
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);
    chk("rst_core_start", core_start, 0);
    @(negedge Clk); #2;
    Rst = 1'b1;
    run_cmp = 1'b1;
    #1;
    chk("rst_release_in_ready", in_ready, 1);

    send(8'd5, 8'hFD, 8'd5, 8'd3, 16'hFFF1, LAT + 1, 0);
    send(8'h80, 8'h80, 8'h80, 8'h80, 16'h4000, LAT + 1, 0);
    send(8'h80, 8'd1, 8'h80, 8'd1, 16'hFF80, LAT + 1, 0);
    send(8'd7, 8'd9, 8'd7, 8'd9, 16'h003F, LAT + 1, 5);

    // Reset while the core is running abandons the pair.
    @(negedge Clk);
    x = 8'd9; y = 8'd3; in_valid = 1'b1;
    @(negedge Clk);
    in_valid = 1'b0;
    @(posedge Clk); #2;
    Rst = 1'b0;
    #1;
    chk("arst_core_x", core_x, 0);
    chk("arst_core_y", core_y, 0);
    chk("arst_core_start", core_start, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_p", p, 0);
    @(negedge Clk); #2;
    Rst = 1'b1;
    repeat (6) @(negedge Clk);
    send(8'd2, 8'd2, 8'd2, 8'd2, 16'h0004, LAT + 1, 0);

    if (BYP) send(8'd0, 8'hF9, 8'd2, 8'd2, 16'h0000, 1, 0);
    else     send(8'd0, 8'hF9, 8'd0, 8'd7, 16'h0000, LAT + 1, 0);

    // Back-to-back stream with in_valid and out_ready held high.
    collect = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      int g;
      g = 0;
      @(negedge Clk);
      x = bx[i]; y = by[i]; in_valid = 1'b1;
      while (!in_ready && g < 50) begin
        @(negedge Clk);
        g++;
      end
      chk("stream_accept_timeout", (g < 50), 1);
      @(posedge Clk); #1;
      acc_t[i] = cyc;
    end
    @(negedge Clk);
    in_valid = 1'b0;
    repeat (3 * LAT + 10) @(negedge Clk);
    collect = 1'b0;
    out_ready = 1'b0;
    chk("stream_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) chk("stream_p", got_q[i], bp[i]);
    for (int i = 1; i < 4; i++) chk("stream_spacing_min", (acc_t[i] - acc_t[i-1] >= LAT + 2), 1);

    repeat (3) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
